// File: rtl/sam_mouse_pkg.sv
// Shared constants and sizing helpers for the SAM Coupe mouse interface.
// The read sequence index q runs 0 (idle), 1 (header), 2 (buttons), then the axis nibbles.
package sam_mouse_pkg;

    localparam int unsigned Q_IDLE = 0;
    localparam int unsigned Q_HDR  = 1;
    localparam int unsigned Q_BTN  = 2;

    function automatic int unsigned last_idx(input int unsigned cnt_w, input int unsigned wheel);
        return 2 + ((wheel != 0) ? 3 : 2) * (cnt_w / 4);
    endfunction

    function automatic int unsigned q_width(input int unsigned cnt_w, input int unsigned wheel);
        return $clog2(last_idx(cnt_w, wheel) + 1);
    endfunction

endpackage

// File: rtl/sam_mouse_axis.sv
// One movement axis: saturating signed accumulator, read snapshot, and post-read subtraction.
// Serves nibble i_nib_sel of the snapshot, nibble 0 being the most significant.
module sam_mouse_axis
    import sam_mouse_pkg::*;
#(
    parameter int unsigned CNT_W = 12
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             i_add,
    input  logic [8:0]       i_delta,
    input  logic             i_latch,
    input  logic             i_sub,
    input  logic [1:0]       i_nib_sel,
    output logic [3:0]       o_nibble
);

    localparam int unsigned N  = CNT_W / 4;
    localparam int unsigned SW = ((CNT_W > 9) ? CNT_W : 9) + 1;

    logic        [CNT_W-1:0] r_acc;
    logic        [CNT_W-1:0] r_snap;
    logic        [CNT_W-1:0] w_sat;
    logic signed [SW-1:0]    w_sum;
    logic signed [SW-1:0]    w_max;
    logic signed [SW-1:0]    w_min;

    // Sum in a domain wide enough for both operands, then clamp back to CNT_W.
    always_comb begin
        w_max = {{(SW-CNT_W+1){1'b0}}, {(CNT_W-1){1'b1}}};
        w_min = ~w_max;
        w_sum = $signed({{(SW-CNT_W){r_acc[CNT_W-1]}}, r_acc})
              + $signed({{(SW-9){i_delta[8]}}, i_delta});
        if (w_sum > w_max)
            w_sat = w_max[CNT_W-1:0];
        else if (w_sum < w_min)
            w_sat = w_min[CNT_W-1:0];
        else
            w_sat = w_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            r_acc <= '0;
        else if (i_sub)
            r_acc <= r_acc - r_snap;
        else if (i_add)
            r_acc <= w_sat;
    end

    always_ff @(posedge clk_sys) begin
        if (i_latch)
            r_snap <= r_acc;
    end

    always_comb begin
        o_nibble = '1;
        for (int unsigned k = 0; k < N; k++) begin
            if (i_nib_sel == 2'(k))
                o_nibble = r_snap[(N-1-k)*4 +: 4];
        end
    end

endmodule

// File: rtl/sam_mouse_gen.sv
// PS/2 to SAM Coupe mouse interface: packet accumulation, rd-driven nibble sequencer and timeout.
// Packet strobes coinciding with an rd rising edge are deferred one cycle so latch/subtract never collide with an add.
module sam_mouse_gen
    import sam_mouse_pkg::*;
#(
    parameter int unsigned CNT_W   = 12,
    parameter int unsigned TIMEOUT = 180,
    parameter int unsigned WHEEL   = 0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_6mp,
    input  logic [24:0] ps2_mouse,
    input  logic [7:0]  ps2_wheel,
    input  logic        rd,
    output logic [4:0]  dout
);

    localparam int unsigned N    = CNT_W / 4;
    localparam int unsigned LAST = last_idx(CNT_W, WHEEL);
    localparam int unsigned QW   = q_width(CNT_W, WHEEL);
    localparam int unsigned TW   = $clog2(TIMEOUT + 2);

    localparam logic [QW-1:0] Q_LAST = QW'(LAST);
    localparam logic [QW-1:0] Q_Y0   = QW'(3);
    localparam logic [QW-1:0] Q_X0   = QW'(3 + N);
    localparam logic [QW-1:0] Q_Z0   = QW'(3 + 2 * N);

    typedef enum logic [2:0] {SEG_CONST, SEG_BTN, SEG_Y, SEG_X, SEG_Z} seg_t;

    logic          r_rd_prev;
    logic          r_strb_prev;
    logic [2:0]    r_buttons;
    logic [QW-1:0] r_q;
    logic [QW-1:0] w_q_next;
    logic [TW-1:0] r_to;

    logic          w_rd_fall;
    logic          w_rd_rise;
    logic          w_add;
    logic          w_latch;
    logic          w_sub;
    logic          w_tmo;
    seg_t          w_seg;
    logic [1:0]    w_sel;
    logic [3:0]    w_nib;
    logic [3:0]    w_y_nib;
    logic [3:0]    w_x_nib;
    logic [3:0]    w_z_nib;
    logic          w_unused;

    assign w_rd_fall = r_rd_prev & ~rd;
    assign w_rd_rise = ~r_rd_prev & rd;
    assign w_add     = (ps2_mouse[24] ^ r_strb_prev) & ~w_rd_rise;
    assign w_latch   = w_rd_rise && (r_q == QW'(Q_BTN));
    assign w_sub     = w_rd_rise && (r_q == Q_LAST);
    assign w_tmo     = ce_6mp && (r_to == TW'(TIMEOUT));
    assign w_unused  = ^{ps2_mouse[7:6], ps2_mouse[3], ps2_wheel};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_rd_prev   <= 1'b0;
            r_strb_prev <= 1'b0;
            r_buttons   <= '0;
        end else begin
            r_rd_prev <= rd;
            // Holding the previous strobe keeps the edge pending for the next cycle.
            if (!w_rd_rise)
                r_strb_prev <= ps2_mouse[24];
            if (w_add)
                r_buttons <= ps2_mouse[2:0];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            r_to <= '0;
        else if (w_rd_rise)
            r_to <= '0;
        else if (ce_6mp && (r_to != TW'(TIMEOUT + 1)))
            r_to <= r_to + TW'(1);
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            r_q <= QW'(Q_IDLE);
        else
            r_q <= w_q_next;
    end

    always_comb begin
        w_q_next = r_q;
        if (w_tmo)
            w_q_next = QW'(Q_IDLE);
        else if (w_rd_fall)
            w_q_next = (r_q == Q_LAST) ? QW'(Q_HDR) : r_q + QW'(1);
    end

    always_comb begin
        w_seg = SEG_CONST;
        w_sel = '0;
        if (r_q == QW'(Q_BTN)) begin
            w_seg = SEG_BTN;
        end else if ((WHEEL != 0) && (r_q >= Q_Z0)) begin
            w_seg = SEG_Z;
            w_sel = 2'(r_q - Q_Z0);
        end else if (r_q >= Q_X0) begin
            w_seg = SEG_X;
            w_sel = 2'(r_q - Q_X0);
        end else if (r_q >= Q_Y0) begin
            w_seg = SEG_Y;
            w_sel = 2'(r_q - Q_Y0);
        end
    end

    always_comb begin
        case (w_seg)
            SEG_BTN: w_nib = {1'b1, ~r_buttons};
            SEG_Y:   w_nib = w_y_nib;
            SEG_X:   w_nib = w_x_nib;
            SEG_Z:   w_nib = w_z_nib;
            default: w_nib = 4'hF;
        endcase
        dout = rd ? 5'h1F : {1'b1, w_nib};
    end

    sam_mouse_axis #(.CNT_W(CNT_W)) u_axis_y (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .i_add     (w_add),
        .i_delta   ({ps2_mouse[5], ps2_mouse[23:16]}),
        .i_latch   (w_latch),
        .i_sub     (w_sub),
        .i_nib_sel (w_sel),
        .o_nibble  (w_y_nib)
    );

    sam_mouse_axis #(.CNT_W(CNT_W)) u_axis_x (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .i_add     (w_add),
        .i_delta   ({ps2_mouse[4], ps2_mouse[15:8]}),
        .i_latch   (w_latch),
        .i_sub     (w_sub),
        .i_nib_sel (w_sel),
        .o_nibble  (w_x_nib)
    );

    generate
        if (WHEEL != 0) begin : g_z
            sam_mouse_axis #(.CNT_W(CNT_W)) u_axis_z (
                .clk_sys   (clk_sys),
                .reset     (reset),
                .i_add     (w_add),
                .i_delta   ({ps2_wheel[7], ps2_wheel}),
                .i_latch   (w_latch),
                .i_sub     (w_sub),
                .i_nib_sel (w_sel),
                .o_nibble  (w_z_nib)
            );
        end else begin : g_no_z
            assign w_z_nib = 4'hF;
        end
    endgenerate

endmodule
